// File: rtl/sseg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// Cycles ON/BLANK per digit, applies per-digit enables and leading-zero
// suppression, and swaps pending display data in only at frame boundaries.
module sseg_scan_ctrl #(
  parameter int unsigned CLK_DIV   = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] data_in,
  input  logic [3:0]  dig_en_in,
  input  logic        lz_in,
  output logic [3:0]  bin_out,
  output logic        seg_blank,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        upd_pending
);

  localparam int unsigned CMAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] ON_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {
    ST_ON,
    ST_BLANK
  } state_t;

  state_t        state, state_n;
  logic [1:0]    dig, dig_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          boundary;

  logic [15:0]   disp_data, pend_data;
  logic [3:0]    disp_en, pend_en;
  logic          disp_lz, pend_lz;
  logic          pend_valid;

  logic [3:0]    lzb;
  logic [3:0]    shown;
  logic          lit;

  // Scan state register: phase, current digit and phase counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BLANK;
      dig   <= 2'd3;
      cnt   <= '0;
    end else begin
      state <= state_n;
      dig   <= dig_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: ON for CLK_DIV cycles, BLANK for BLANK_CYC, then next digit.
  always_comb begin
    state_n  = state;
    dig_n    = dig;
    cnt_n    = cnt + CW'(1);
    boundary = 1'b0;
    case (state)
      ST_ON: begin
        if (cnt == ON_LAST) begin
          state_n = ST_BLANK;
          cnt_n   = '0;
        end
      end
      ST_BLANK: begin
        if (cnt == BL_LAST) begin
          state_n  = ST_ON;
          dig_n    = dig + 2'd1;
          cnt_n    = '0;
          boundary = (dig == 2'd3);
        end
      end
    endcase
  end

  // Pending/display word registers; a write on the boundary cycle still
  // lets the previous pending word reach the display first.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_data  <= '0;
      disp_en    <= '0;
      disp_lz    <= 1'b0;
      pend_data  <= '0;
      pend_en    <= '0;
      pend_lz    <= 1'b0;
      pend_valid <= 1'b0;
    end else begin
      if (boundary && pend_valid) begin
        disp_data <= pend_data;
        disp_en   <= pend_en;
        disp_lz   <= pend_lz;
      end
      if (wr_en) begin
        pend_data  <= data_in;
        pend_en    <= dig_en_in;
        pend_lz    <= lz_in;
        pend_valid <= 1'b1;
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Output decode from registered state only. bin_out needs no holding
  // register: dig and disp change only on entry to ON, so during BLANK the
  // same nibble as the preceding ON phase is selected.
  always_comb begin
    lzb[0]      = 1'b0;
    lzb[1]      = disp_lz & (disp_data[15:4]  == 12'h000);
    lzb[2]      = disp_lz & (disp_data[15:8]  == 8'h00);
    lzb[3]      = disp_lz & (disp_data[15:12] == 4'h0);
    shown       = disp_en & ~lzb;
    lit         = (state == ST_ON) & shown[dig];
    an          = lit ? ~(4'b0001 << dig) : 4'b1111;
    seg_blank   = ~lit;
    bin_out     = disp_data[{dig, 2'b00} +: 4];
    frame_done  = (state == ST_ON) && (dig == 2'd0) && (cnt == '0);
    upd_pending = pend_valid;
  end

endmodule
